cam_sccb_config: RTL
====================

Name: cam_sccb_config

Overview:
- Power-up configuration sequencer for the parallel 8-bit camera on the expansion header.
- On a start pulse it:
  - pulses the camera hardware reset;
  - walks an external synchronous ROM of {reg_addr, reg_data} entries;
  - issues one SCCB 3-phase write per entry, honouring delay entries;
  - signals done.
- Sits beside the camera capture path; its outputs drive the camera's SIOC, SIOD (open-drain) and RESET_N pins.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency.
- SCCB_HZ, 100_000, SIOC bit rate. QTR = CLK_HZ/(4*SCCB_HZ) cycles per quarter-bit; must be ≥2.
- DEV_ADDR, 8'h42, 8-bit SCCB write address, with bit0 forced to 0.
- ROM_LEN, 64, number of ROM entries (≥1).
- RST_CYCLES, 50_000, length of the reset-low time, and separately of the post-reset wait.
- DELAY_UNIT, 50_000, cycles per count in a delay entry.
- CHECK_ACK, 1, when 1 a high ack bit sets error.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to run the sequence.
- busy  out  1  high from start acceptance until DONE.
- done  out  1  high in DONE; cleared by the next accepted start.
- error  out  1  sticky NACK flag; cleared by an accepted start.
- rom_index  out  $clog2(ROM_LEN)  ROM address.
- rom_data  in  16  {reg_addr[15:8], reg_data[7:0]}, valid 1 cycle after rom_index.
- sioc  out  1  SCCB clock (push-pull).
- siod_oe  out  1  1 = pull SIOD low, 0 = release.
- siod_in  in  1  sampled SIOD pin.
- cam_rst_n  out  1  camera hardware reset, active low.

Behaviour:
- Reset values:
  - sioc=1, siod_oe=0, cam_rst_n=1;
  - busy=0, done=0, error=0, rom_index=0;
  - state IDLE.
  - Reset mid-transfer releases the bus on the next edge; no stop is generated.
- Start handling:
  - start is accepted only in IDLE or DONE; ignored while busy.
  - On acceptance: busy=1, done=0, error=0, rom_index=0.
- States:
  - IDLE → (start) HW_RST.
  - HW_RST: cam_rst_n=0 for RST_CYCLES → HW_WAIT.
  - HW_WAIT: cam_rst_n=1 for RST_CYCLES → FETCH.
  - FETCH: 1 cycle for ROM latency → DECODE.
  - DECODE:
    - reg_addr==8'hFF → DELAY, for reg_data*DELAY_UNIT cycles; 0 = no wait.
    - otherwise → WRITE, with a go pulse to the writer.
  - WRITE: wait for writer ready → NEXT.
  - DELAY: count down → NEXT.
  - NEXT:
    - rom_index==ROM_LEN-1 → DONE (busy=0, done=1);
    - else rom_index+1 → FETCH.
  - DONE → (start) HW_RST.
- Write frame: 30 slots of 4 quarters each, 120*QTR cycles total.
  - Slot 0, START:
    - q0–q1: sioc=1, released;
    - q2–q3: sioc=1, siod_oe=1.
  - Slots 1–27: three 9-bit phases, in order DEV_ADDR, reg_addr, reg_data.
    - Each phase is 8 bits MSB-first plus a don't-care bit.
    - Data bit timing:
      - q0–q1: sioc=0, siod_oe=~bit;
      - q2–q3: sioc=1.
    - The 9th bit of each phase releases SIOD; siod_in is sampled on the last cycle of q2.
    - If CHECK_ACK and the sample is 1 → error=1.
  - Slot 28, STOP:
    - q0–q2: siod_oe=1, with sioc 0,0,1;
    - q3: sioc=1, released.
  - Slot 29, GAP: sioc=1, released.
  - Writer ready rises the cycle after slot 29 ends.
- SIOD changes only while sioc=0, except in START and STOP.
- Writer latency from go to ready = 120*QTR+1 cycles.
- Counters saturate at nothing: widths are sized by $clog2 of the largest count; the delay counter is sized for 255*DELAY_UNIT.

Decomposition:
- Package cam_cfg_pkg:
  - state enum;
  - slot constants (SLOT_START=0, SLOT_STOP=28, SLOT_GAP=29, SLOTS=30);
  - DELAY_MARK=8'hFF.
- Sub-module sccb_write:
  - inputs: go, dev, addr, data, siod_in;
  - outputs: ready, sioc, siod_oe, nack;
  - owns the quarter/slot counters.
- The top owns the sequencing FSM, reset timing and delay counter.

Test Plan:
All scenarios use CLK_HZ=1600, SCCB_HZ=100 (QTR=4), RST_CYCLES=8, DELAY_UNIT=10, ROM_LEN=3.
- ROM={12_80, FF_03, 11_01}, start pulse:
  - cam_rst_n low exactly 8 cycles, then 8-cycle wait;
  - decoded SIOD bytes 42,12,80 then 42,11,01;
  - 30-cycle gap between the two writes (plus fetch/decode cycles);
  - done=1 and busy=0 afterwards.
- Bus protocol check on every write:
  - SIOD never changes while SIOC high, except START (fall) and STOP (rise);
  - each write spans exactly 480 cycles.
- siod_in forced 1 during the second ack bit, CHECK_ACK=1:
  - error=1 and stays set;
  - the sequence still completes;
  - next start clears error.
- start re-pulsed while busy:
  - ignored;
  - rom_index progression and write count unchanged.
- reset asserted mid-frame (slot 10):
  - next cycle sioc=1, siod_oe=0, cam_rst_n=1, busy=0;
  - a new start runs the full sequence cleanly.
- ROM_LEN=1 with entry FF_00:
  - zero-length delay;
  - no SCCB activity;
  - done asserted RST_CYCLES*2 + 4 cycles (±1) after start.

Source files
------------

// File: rtl/cam_cfg_pkg.sv
// Shared types and constants for the camera SCCB configuration sequencer.
package cam_cfg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HW_RST,
    ST_HW_WAIT,
    ST_FETCH,
    ST_DECODE,
    ST_WRITE,
    ST_DELAY,
    ST_NEXT,
    ST_DONE
  } cfg_state_t;

  localparam int SLOT_START = 0;
  localparam int SLOT_STOP  = 28;
  localparam int SLOT_GAP   = 29;
  localparam int SLOTS      = 30;
  localparam int FRAME_BITS = 27;

  localparam logic [7:0] DELAY_MARK = 8'hFF;

endpackage

// File: rtl/cam_sccb_config_sccb_write.sv
// One SCCB 3-phase write: START, dev/addr/data with don't-care bits, STOP, then an idle gap slot.
module sccb_write
  import cam_cfg_pkg::*;
#(
  parameter int QTR       = 125,
  parameter bit CHECK_ACK = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic [7:0] dev,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  input  logic       siod_in,
  output logic       ready,
  output logic       sioc,
  output logic       siod_oe,
  output logic       nack
);

  localparam int QW = (QTR > 1) ? $clog2(QTR) : 1;

  logic                  active;
  logic [QW-1:0]         qtr_cnt;
  logic [1:0]            quarter;
  logic [4:0]            slot;
  logic [FRAME_BITS-1:0] frame;
  logic                  qtr_end;
  logic                  ack_slot;
  logic                  bit_val;

  assign qtr_end  = (qtr_cnt == QW'(QTR - 1));
  assign ack_slot = (slot == 5'd9) || (slot == 5'd18) || (slot == 5'd27);
  // Slot 1 carries frame MSB; the trailing 1 of each byte releases SIOD for the ack.
  assign bit_val  = frame[5'(FRAME_BITS) - slot];

  always_ff @(posedge clk) begin
    if (reset) begin
      active  <= 1'b0;
      qtr_cnt <= '0;
      quarter <= '0;
      slot    <= '0;
      frame   <= '0;
      ready   <= 1'b0;
      nack    <= 1'b0;
    end else begin
      ready <= 1'b0;
      nack  <= 1'b0;
      if (!active) begin
        if (go) begin
          active  <= 1'b1;
          qtr_cnt <= '0;
          quarter <= '0;
          slot    <= '0;
          frame   <= {dev[7:1], 1'b0, 1'b1, addr, 1'b1, data, 1'b1};
        end
      end else begin
        if (CHECK_ACK && ack_slot && (quarter == 2'd2) && qtr_end && siod_in)
          nack <= 1'b1;
        if (qtr_end) begin
          qtr_cnt <= '0;
          quarter <= quarter + 2'd1;
          if (quarter == 2'd3) begin
            if (slot == 5'(SLOT_GAP)) begin
              active <= 1'b0;
              ready  <= 1'b1;
            end else begin
              slot <= slot + 5'd1;
            end
          end
        end else begin
          qtr_cnt <= qtr_cnt + QW'(1);
        end
      end
    end
  end

  always_comb begin
    sioc    = 1'b1;
    siod_oe = 1'b0;
    if (active) begin
      if (slot == 5'(SLOT_START)) begin
        siod_oe = quarter[1];
      end else if (slot == 5'(SLOT_STOP)) begin
        sioc    = quarter[1];
        siod_oe = (quarter != 2'd3);
      end else if (slot < 5'(SLOT_STOP)) begin
        sioc    = quarter[1];
        siod_oe = ~bit_val;
      end
    end
  end

endmodule

// File: rtl/cam_sccb_config.sv
// Camera power-up sequencer: hardware reset pulse, then one SCCB write per ROM entry with delay entries.
module cam_sccb_config
  import cam_cfg_pkg::*;
#(
  parameter int         CLK_HZ     = 50_000_000,
  parameter int         SCCB_HZ    = 100_000,
  parameter logic [7:0] DEV_ADDR   = 8'h42,
  parameter int         ROM_LEN    = 64,
  parameter int         RST_CYCLES = 50_000,
  parameter int         DELAY_UNIT = 50_000,
  parameter bit         CHECK_ACK  = 1'b1,
  localparam int        IDX_W      = (ROM_LEN > 1) ? $clog2(ROM_LEN) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] rom_index,
  input  logic [15:0]      rom_data,
  output logic             sioc,
  output logic             siod_oe,
  input  logic             siod_in,
  output logic             cam_rst_n
);

  localparam int QTR     = CLK_HZ / (4 * SCCB_HZ);
  localparam int MAX_CNT = (RST_CYCLES > 255 * DELAY_UNIT) ? RST_CYCLES : 255 * DELAY_UNIT;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_U    = CNT_W'(DELAY_UNIT);
  localparam logic [IDX_W-1:0] LAST     = IDX_W'(ROM_LEN - 1);

  cfg_state_t       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             wr_go, wr_ready, wr_nack;

  sccb_write #(.QTR(QTR), .CHECK_ACK(CHECK_ACK)) u_write (
    .clk     (clk),
    .reset   (reset),
    .go      (wr_go),
    .dev     (DEV_ADDR & 8'hFE),
    .addr    (rom_data[15:8]),
    .data    (rom_data[7:0]),
    .siod_in (siod_in),
    .ready   (wr_ready),
    .sioc    (sioc),
    .siod_oe (siod_oe),
    .nack    (wr_nack)
  );

  assign cam_rst_n = (state != ST_HW_RST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rom_index <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state <= state_next;
      if (wr_nack) error <= 1'b1;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            rom_index <= '0;
            cnt       <= RST_LOAD;
          end
        end
        // The same count reloads so the post-reset wait matches the low time.
        ST_HW_RST: cnt <= (cnt == '0) ? RST_LOAD : cnt - CNT_W'(1);
        ST_HW_WAIT, ST_DELAY: if (cnt != '0) cnt <= cnt - CNT_W'(1);
        ST_DECODE: cnt <= CNT_W'(rom_data[7:0]) * DLY_U - CNT_W'(1);
        ST_NEXT: begin
          if (rom_index == LAST) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            rom_index <= rom_index + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    wr_go      = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_next = ST_HW_RST;
      ST_HW_RST:  if (cnt == '0) state_next = ST_HW_WAIT;
      ST_HW_WAIT: if (cnt == '0) state_next = ST_FETCH;
      ST_FETCH:   state_next = ST_DECODE;
      ST_DECODE: begin
        if (rom_data[15:8] == DELAY_MARK) begin
          state_next = (rom_data[7:0] == 8'd0) ? ST_NEXT : ST_DELAY;
        end else begin
          state_next = ST_WRITE;
          wr_go      = 1'b1;
        end
      end
      ST_WRITE: if (wr_ready) state_next = ST_NEXT;
      ST_DELAY: if (cnt == '0) state_next = ST_NEXT;
      ST_NEXT:  state_next = (rom_index == LAST) ? ST_DONE : ST_FETCH;
      default:  state_next = ST_IDLE;
    endcase
  end

endmodule
